pio_bus_master: RTL and testbench
=================================

// Module: pio_bus_master
// PURPOSE
//  Avalon-MM initiator driving the zero-wait-state PIO slaves (chipselect/write_n/address/writedata/readdata).
//  Accepts write/read commands from an on-chip controller via a valid/ready port, buffers them in a FIFO,
//  and issues them one at a time on the PIO bus. Read data returns on a valid/ready response port.
//  Sits between the FMA operand/result sequencer and the memory-mapped PIO operand and result registers.
// PARAMETERS
//  ADDR_W        2   PIO bus address width (word address)
//  DATA_W        32  bus data width; PIO slaves use the low bits
//  DEPTH         4   command FIFO depth, power of two, >= 2
//  READ_LATENCY  0   cycles from the read-issue cycle to valid readdata (0 = same cycle, combinational slave)
// PORTS
//  clk          in   1         clock; all logic on rising edge
//  reset        in   1         synchronous, active-high reset
//  cmd_valid    in   1         command present
//  cmd_ready    out  1         FIFO can accept; transfer when cmd_valid && cmd_ready
//  cmd_write    in   1         1 = write, 0 = read
//  cmd_addr     in   ADDR_W    target word address
//  cmd_wdata    in   DATA_W    write data (ignored for reads)
//  rsp_valid    out  1         read data available
//  rsp_ready    in   1         consumer accepts response
//  rsp_data     out  DATA_W    captured readdata
//  address      out  ADDR_W    PIO bus address
//  chipselect   out  1         PIO bus select, one cycle per access
//  write_n      out  1         PIO bus write strobe, active low
//  writedata    out  DATA_W    PIO bus write data
//  readdata     in   DATA_W    PIO bus read data
//  busy         out  1         FIFO non-empty or FSM not in IDLE
//  fifo_level   out  log2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (sync, reset=1 at rising edge): FIFO emptied, FSM=IDLE; chipselect=0, write_n=1, address=0,
//   writedata=0, rsp_valid=0, rsp_data=0, busy=0, fifo_level=0, cmd_ready=1 from the next cycle on.
//   Reset mid-access aborts it: pending read response and all queued commands are discarded.
//  FIFO: cmd_ready = (fifo_level != DEPTH), registered from occupancy; a push while full is impossible.
//   Push and pop in the same cycle leave fifo_level unchanged; a push into an empty FIFO is poppable next cycle.
//  FSM states IDLE, ISSUE, WAIT_RD, RESP:
//   IDLE: if FIFO non-empty, pop head into command register -> ISSUE; else stay.
//   ISSUE: chipselect=1 for exactly this cycle, address/writedata from command, write_n=~cmd_write.
//     write -> IDLE. read with READ_LATENCY=0: rsp_data<=readdata at this edge -> RESP.
//     read with READ_LATENCY>0 -> WAIT_RD, latency counter loaded with READ_LATENCY.
//   WAIT_RD: chipselect=0, write_n=1; decrement counter; at 1, capture readdata -> RESP.
//   RESP: rsp_valid=1, rsp_data stable until rsp_valid && rsp_ready -> IDLE. No bus access while in RESP.
//  Bus outputs are registered; outside ISSUE, chipselect=0 and write_n=1; address/writedata hold last value.
//  Ordering strictly FIFO; one access outstanding. Write cost = 2 cycles (IDLE pop + ISSUE);
//   back-to-back writes give chipselect pulses every second cycle.
//  Read cost = 2 + READ_LATENCY cycles + response wait.
//  cmd_addr and cmd_wdata are stored unmodified; the high bits of readdata are captured as presented.
// TESTING
//  Single write addr=0 data=0x5A -> exactly one cycle with chipselect=1, write_n=0, address=0, writedata=0x5A.
//  Read addr=0 with slave returning 0xFF, READ_LATENCY=0, rsp_ready=1 -> rsp_valid one cycle, rsp_data=0xFF.
//  Push 4 writes with DEPTH=4 and bus stalled by RESP of a prior read -> cmd_ready=0 at level 4; 5th cmd_valid held, not lost.
//  Write 0x12 then read addr 0, rsp_ready low 10 cycles -> rsp_data=0x12 held stable; no chipselect until accepted.
//  READ_LATENCY=2: slave drives 0xA5 two cycles after issue -> rsp_data=0xA5; a value presented earlier is not captured.
//  Assert reset during WAIT_RD with 3 queued cmds -> next cycle chipselect=0, rsp_valid=0, fifo_level=0, busy=0.

Source files
------------

// File: rtl/pio_bus_master.sv
// pio_bus_master: queues PIO read/write commands and issues them one at a time
// on a zero-wait-state Avalon-MM PIO bus, returning read data on a response port.
module pio_bus_master #(
    parameter int unsigned ADDR_W       = 2,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned READ_LATENCY = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_W-1:0]       cmd_addr,
    input  logic [DATA_W-1:0]       cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [ADDR_W-1:0]       address,
    output logic                    chipselect,
    output logic                    write_n,
    output logic [DATA_W-1:0]       writedata,
    input  logic [DATA_W-1:0]       readdata,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    cmd_t             mem [DEPTH];
    cmd_t             cmd_in;
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_nxt;
    logic             cur_write;
    logic [CNT_W-1:0] lat_cnt;
    logic             push;
    logic             pop;

    assign cmd_in = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    assign head   = mem[rd_ptr];
    assign push   = cmd_valid && cmd_ready;
    assign pop    = (state == IDLE) && (fifo_level != '0);

    // Occupancy after this cycle's push/pop.
    always_comb begin
        level_nxt = fifo_level;
        if (push && !pop) begin
            level_nxt = fifo_level + LVL_W'(1);
        end else if (!push && pop) begin
            level_nxt = fifo_level - LVL_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: one bus access outstanding at a time.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (cur_write) begin
                    state_nxt = IDLE;
                end else if (READ_LATENCY == 0) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (lat_cnt == CNT_W'(1)) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO storage; pointers reset elsewhere so contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_in;
        end
    end

    // FIFO pointers, registered bus outputs, read capture and status.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            address    <= '0;
            writedata  <= '0;
            cur_write  <= 1'b0;
            lat_cnt    <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
        end else begin
            fifo_level <= level_nxt;
            cmd_ready  <= (level_nxt != LVL_W'(DEPTH));
            busy       <= (level_nxt != '0) || (state_nxt != IDLE);
            rsp_valid  <= (state_nxt == RESP);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            // Popping loads the bus registers so they present the access during ISSUE.
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                address    <= head.addr;
                writedata  <= head.wdata;
                write_n    <= ~head.write;
                cur_write  <= head.write;
                chipselect <= 1'b1;
            end else begin
                chipselect <= 1'b0;
                write_n    <= 1'b1;
            end
            if ((state == ISSUE) && !cur_write) begin
                if (READ_LATENCY == 0) begin
                    rsp_data <= readdata;
                end else begin
                    lat_cnt <= CNT_W'(READ_LATENCY);
                end
            end
            if (state == WAIT_RD) begin
                lat_cnt <= lat_cnt - CNT_W'(1);
                if (lat_cnt == CNT_W'(1)) begin
                    rsp_data <= readdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_pio_bus_master.sv
// tb_pio_bus_master: directed and randomized checks of pio_bus_master with a
// combinational slave (READ_LATENCY=0) and a delayed slave (READ_LATENCY=2).
module tb_pio_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: READ_LATENCY = 0, backed by a register-file slave.
    logic        reset0, cv0, cr0, cw0, rv0, rr0, cs0, wn0, busy0;
    logic [1:0]  ca0, a0;
    logic [31:0] cd0, rd0, wd0, rdd0;
    logic [2:0]  lvl0;

    // Instance 2: READ_LATENCY = 2, readdata driven directly by the bench.
    logic        reset2, cv2, cr2, cw2, rv2, rr2, cs2, wn2, busy2;
    logic [1:0]  ca2, a2;
    logic [31:0] cd2, rd2, wd2, rdd2;
    logic [2:0]  lvl2;

    pio_bus_master #(.ADDR_W(2), .DATA_W(32), .DEPTH(4), .READ_LATENCY(0)) dut0 (
        .clk(clk), .reset(reset0), .cmd_valid(cv0), .cmd_ready(cr0), .cmd_write(cw0),
        .cmd_addr(ca0), .cmd_wdata(cd0), .rsp_valid(rv0), .rsp_ready(rr0), .rsp_data(rd0),
        .address(a0), .chipselect(cs0), .write_n(wn0), .writedata(wd0), .readdata(rdd0),
        .busy(busy0), .fifo_level(lvl0)
    );

    pio_bus_master #(.ADDR_W(2), .DATA_W(32), .DEPTH(4), .READ_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset2), .cmd_valid(cv2), .cmd_ready(cr2), .cmd_write(cw2),
        .cmd_addr(ca2), .cmd_wdata(cd2), .rsp_valid(rv2), .rsp_ready(rr2), .rsp_data(rd2),
        .address(a2), .chipselect(cs2), .write_n(wn2), .writedata(wd2), .readdata(rdd2),
        .busy(busy2), .fifo_level(lvl2)
    );

    // Zero-wait-state PIO slave for instance 0.
    logic [31:0] smem0 [4];
    assign rdd0 = smem0[a0];
    always @(posedge clk) begin
        if (cs0 && !wn0) smem0[a0] <= wd0;
    end

    typedef struct {
        logic        wn;
        logic [1:0]  addr;
        logic [31:0] data;
        int          cyc;
    } acc_t;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
    } cmd_t;

    // Bus and response monitor, sampled on the falling edge.
    acc_t        seen0[$];
    logic [31:0] rsp0[$];
    int          cyc = 0;
    int          rv_cnt0 = 0;
    int          cs_cnt2 = 0;
    always @(negedge clk) begin
        cyc++;
        if (cs0) seen0.push_back('{wn0, a0, wd0, cyc});
        if (rv0) rv_cnt0++;
        if (rv0 && rr0) rsp0.push_back(rd0);
        if (cs2) cs_cnt2++;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic w, input logic [1:0] a, input logic [31:0] d);
        int n = 0;
        cv0 = 1'b1; cw0 = w; ca0 = a; cd0 = d;
        while (!cr0 && n < 50) begin tick(); n++; end
        chk("push0_ready", 32'(cr0), 32'd1);
        tick();
        cv0 = 1'b0;
    endtask

    task automatic push2(input logic w, input logic [1:0] a, input logic [31:0] d);
        int n = 0;
        cv2 = 1'b1; cw2 = w; ca2 = a; cd2 = d;
        while (!cr2 && n < 50) begin tick(); n++; end
        chk("push2_ready", 32'(cr2), 32'd1);
        tick();
        cv2 = 1'b0;
    endtask

    task automatic wait_rv0(input string tag);
        int n = 0;
        while (!rv0 && n < 50) begin tick(); n++; end
        chk(tag, 32'(rv0), 32'd1);
    endtask

    cmd_t        cmds[$];
    cmd_t        exp_bus[$];
    logic [31:0] exp_rsp[$];
    logic [31:0] ref_mem [4];

    initial begin
        int b, rb, rvc, csc, n, idx;
        logic fire;
        cmd_t c;

        reset0 = 1'b1; reset2 = 1'b1;
        cv0 = 1'b0; cw0 = 1'b0; ca0 = '0; cd0 = '0; rr0 = 1'b1;
        cv2 = 1'b0; cw2 = 1'b0; ca2 = '0; cd2 = '0; rr2 = 1'b0; rdd2 = '0;
        repeat (3) tick();
        reset0 = 1'b0; reset2 = 1'b0;
        tick();

        // Reset state
        chk("rst_cs", 32'(cs0), 32'd0);
        chk("rst_wn", 32'(wn0), 32'd1);
        chk("rst_addr", 32'(a0), 32'd0);
        chk("rst_wdata", wd0, 32'd0);
        chk("rst_rv", 32'(rv0), 32'd0);
        chk("rst_rdata", rd0, 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_level", 32'(lvl0), 32'd0);
        chk("rst_ready", 32'(cr0), 32'd1);
        chk("rst2_ready", 32'(cr2), 32'd1);

        // Single write: exactly one chipselect cycle with the right bus values
        b = seen0.size();
        push0(1'b1, 2'd0, 32'h5A);
        repeat (6) tick();
        chk("wr1_count", 32'(seen0.size() - b), 32'd1);
        if (seen0.size() > b) begin
            chk("wr1_wn", 32'(seen0[b].wn), 32'd0);
            chk("wr1_addr", 32'(seen0[b].addr), 32'd0);
            chk("wr1_data", seen0[b].data, 32'h5A);
        end
        chk("wr1_idle_busy", 32'(busy0), 32'd0);

        // Read back 0xFF with rsp_ready high: one response cycle
        push0(1'b1, 2'd0, 32'hFF);
        rvc = rv_cnt0; rb = rsp0.size();
        rr0 = 1'b1;
        push0(1'b0, 2'd0, 32'h0);
        repeat (8) tick();
        chk("rd1_rv_cycles", 32'(rv_cnt0 - rvc), 32'd1);
        chk("rd1_count", 32'(rsp0.size() - rb), 32'd1);
        if (rsp0.size() > rb) chk("rd1_data", rsp0[rb], 32'hFF);

        // Fill FIFO while a read sits in RESP; fifth command must be held, not lost
        rr0 = 1'b0;
        rb = rsp0.size();
        push0(1'b0, 2'd0, 32'h0);
        wait_rv0("fill_rv");
        b = seen0.size();
        for (int i = 0; i < 4; i++) push0(1'b1, 2'(i), 32'h100 + 32'(i));
        chk("full_ready", 32'(cr0), 32'd0);
        chk("full_level", 32'(lvl0), 32'd4);
        cv0 = 1'b1; cw0 = 1'b1; ca0 = 2'd0; cd0 = 32'h104;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("held_ready", 32'(cr0), 32'd0);
            chk("held_level", 32'(lvl0), 32'd4);
        end
        rr0 = 1'b1;
        push0(1'b1, 2'd0, 32'h104);
        repeat (20) tick();
        chk("fill_rsp_count", 32'(rsp0.size() - rb), 32'd1);
        if (rsp0.size() > rb) chk("fill_rsp_data", rsp0[rb], 32'hFF);
        chk("fill_bus_count", 32'(seen0.size() - b), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (seen0.size() > b + k) begin
                chk("fill_addr", 32'(seen0[b+k].addr), 32'(k % 4));
                chk("fill_data", seen0[b+k].data, 32'h100 + 32'(k));
                chk("fill_wn", 32'(seen0[b+k].wn), 32'd0);
                if (k > 0) chk("fill_spacing", 32'(seen0[b+k].cyc - seen0[b+k-1].cyc), 32'd2);
            end
        end

        // Write 0x12 then read; response held stable with no bus traffic
        rr0 = 1'b0;
        push0(1'b1, 2'd1, 32'h12);
        push0(1'b0, 2'd1, 32'h0);
        wait_rv0("hold_rv");
        b = seen0.size();
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 32'(rv0), 32'd1);
            chk("hold_data", rd0, 32'h12);
            tick();
        end
        chk("hold_no_cs", 32'(seen0.size() - b), 32'd0);
        rr0 = 1'b1;
        tick();
        chk("hold_released", 32'(rv0), 32'd0);

        // READ_LATENCY=2: only the value two cycles after issue is captured
        push2(1'b0, 2'd0, 32'h0);
        n = 0;
        while (!cs2 && n < 20) begin tick(); n++; end
        chk("lat_issue", 32'(cs2), 32'd1);
        chk("lat_issue_wn", 32'(wn2), 32'd1);
        rdd2 = 32'h33;
        tick();
        chk("lat_early1", 32'(rv2), 32'd0);
        chk("lat_cs_drop", 32'(cs2), 32'd0);
        rdd2 = 32'h77;
        tick();
        chk("lat_early2", 32'(rv2), 32'd0);
        rdd2 = 32'hA5;
        tick();
        rdd2 = 32'h0;
        chk("lat_rv", 32'(rv2), 32'd1);
        chk("lat_data", rd2, 32'hA5);
        repeat (3) tick();
        chk("lat_data_hold", rd2, 32'hA5);
        rr2 = 1'b1;
        tick();
        chk("lat_released", 32'(rv2), 32'd0);
        rr2 = 1'b0;
        tick();

        // Reset during WAIT_RD with three commands queued
        push2(1'b0, 2'd0, 32'h0);
        push2(1'b1, 2'd1, 32'h1);
        push2(1'b1, 2'd2, 32'h2);
        push2(1'b1, 2'd3, 32'h3);
        chk("pre_rst_level", 32'(lvl2), 32'd3);
        chk("pre_rst_busy", 32'(busy2), 32'd1);
        chk("pre_rst_cs", 32'(cs2), 32'd0);
        reset2 = 1'b1;
        tick();
        reset2 = 1'b0;
        chk("mid_rst_cs", 32'(cs2), 32'd0);
        chk("mid_rst_rv", 32'(rv2), 32'd0);
        chk("mid_rst_level", 32'(lvl2), 32'd0);
        chk("mid_rst_busy", 32'(busy2), 32'd0);
        chk("mid_rst_ready", 32'(cr2), 32'd1);
        csc = cs_cnt2;
        repeat (8) tick();
        chk("mid_rst_discard", 32'(cs_cnt2 - csc), 32'd0);
        chk("mid_rst_rv_after", 32'(rv2), 32'd0);

        // Randomized traffic against an in-order memory reference model
        for (int a = 0; a < 4; a++) cmds.push_back('{1'b1, 2'(a), $urandom});
        for (int i = 0; i < 120; i++) begin
            c.wr = ($urandom_range(1) == 1);
            c.addr = 2'($urandom_range(3));
            c.data = $urandom;
            cmds.push_back(c);
        end
        foreach (cmds[i]) begin
            if (cmds[i].wr) ref_mem[cmds[i].addr] = cmds[i].data;
            else exp_rsp.push_back(ref_mem[cmds[i].addr]);
            exp_bus.push_back(cmds[i]);
        end
        b = seen0.size(); rb = rsp0.size(); idx = 0; n = 0;
        while ((idx < cmds.size() || (rsp0.size() - rb) < exp_rsp.size()) && n < 5000) begin
            cv0 = (idx < cmds.size()) && ($urandom_range(3) != 0);
            if (idx < cmds.size()) begin
                cw0 = cmds[idx].wr; ca0 = cmds[idx].addr; cd0 = cmds[idx].data;
            end
            rr0 = ($urandom_range(1) == 1);
            chk("rand_ready_vs_level", 32'(cr0), 32'(lvl0 != 3'd4));
            fire = cv0 && cr0;
            tick();
            n++;
            if (fire) idx++;
        end
        cv0 = 1'b0; rr0 = 1'b1;
        chk("rand_timeout", 32'(n < 5000), 32'd1);
        repeat (5) tick();
        chk("rand_busy_end", 32'(busy0), 32'd0);
        chk("rand_level_end", 32'(lvl0), 32'd0);
        chk("rand_bus_count", 32'(seen0.size() - b), 32'(exp_bus.size()));
        chk("rand_rsp_count", 32'(rsp0.size() - rb), 32'(exp_rsp.size()));
        foreach (exp_bus[k]) begin
            if (seen0.size() > b + k) begin
                chk("rand_bus_wn", 32'(seen0[b+k].wn), 32'(!exp_bus[k].wr));
                chk("rand_bus_addr", 32'(seen0[b+k].addr), 32'(exp_bus[k].addr));
                if (exp_bus[k].wr) chk("rand_bus_data", seen0[b+k].data, exp_bus[k].data);
            end
        end
        foreach (exp_rsp[k]) begin
            if (rsp0.size() > rb + k) chk("rand_rsp_data", rsp0[rb+k], exp_rsp[k]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
